axi_burst_master: RTL and testbench

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

---
 rtl/axi_pkg.sv | 7 +
 rtl/axi_burst_master.sv | 132 +++++++++++++
 tb/tb_axi_burst_master.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: FSM state encoding and AXI4 constants shared by the burst master.
package axi_pkg;
   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi_burst_master.sv
// axi_burst_master: AXI4 INCR burst master for cache-line refill and writeback.
module axi_burst_master
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int BLOCK_WORDS = 16
) (
   input  logic                             clk,
   input  logic                             arst,
   input  logic                             i_start_read,
   input  logic                             i_start_write,
   input  logic [ADDR_WIDTH-1:0]            i_addr,
   input  logic [DATA_WIDTH-1:0]            i_write_data,
   output logic [$clog2(BLOCK_WORDS)-1:0]   o_write_beat_idx,
   output logic [$clog2(BLOCK_WORDS)-1:0]   o_read_beat_idx,
   output logic [DATA_WIDTH-1:0]            o_read_data,
   output logic                             o_read_beat_valid,
   output logic                             o_read_last,
   output logic                             o_b_resp,
   output logic                             o_busy,
   output logic                             o_error,
   output logic [ADDR_WIDTH-1:0]            o_araddr,
   output logic [7:0]                       o_arlen,
   output logic [2:0]                       o_arsize,
   output logic [1:0]                       o_arburst,
   output logic                             o_arvalid,
   input  logic                             i_arready,
   input  logic [DATA_WIDTH-1:0]            i_rdata,
   input  logic [1:0]                       i_rresp,
   input  logic                             i_rlast,
   input  logic                             i_rvalid,
   output logic                             o_rready,
   output logic [ADDR_WIDTH-1:0]            o_awaddr,
   output logic [7:0]                       o_awlen,
   output logic [2:0]                       o_awsize,
   output logic [1:0]                       o_awburst,
   output logic                             o_awvalid,
   input  logic                             i_awready,
   output logic [DATA_WIDTH-1:0]            o_wdata,
   output logic [DATA_WIDTH/8-1:0]          o_wstrb,
   output logic                             o_wlast,
   output logic                             o_wvalid,
   input  logic                             i_wready,
   input  logic [1:0]                       i_bresp,
   input  logic                             i_bvalid,
   output logic                             o_bready
);
   localparam int CW = $clog2(BLOCK_WORDS);
   localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_WORDS - 1);
   state_t                  r_state, w_next;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [CW-1:0]           r_cnt, r_ridx;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic                    r_rbv, r_rlast, r_bresp, r_err;
   logic                    w_start, w_last;
   assign w_start = (r_state == S_IDLE) && (i_start_read || i_start_write);
   assign w_last  = r_cnt == LAST_IDX;
   always_ff @(posedge clk or negedge arst)
      if (!arst) r_state <= S_IDLE;
      else       r_state <= w_next;
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  w_next = i_start_write ? S_AW : i_start_read ? S_AR : S_IDLE;
         S_AR:    w_next = i_arready ? S_R : S_AR;
         S_R:     w_next = (i_rvalid && i_rlast) ? S_IDLE : S_R;
         S_AW:    w_next = i_awready ? S_W : S_AW;
         S_W:     w_next = (i_wready && w_last) ? S_B : S_W;
         S_B:     w_next = i_bvalid ? S_IDLE : S_B;
         default: w_next = S_IDLE;
      endcase
   end
   // One counter serves both directions; it saturates so a missing rlast cannot wrap it.
   always_ff @(posedge clk or negedge arst)
      if (!arst) begin
         r_addr  <= '0;
         r_cnt   <= '0;
         r_ridx  <= '0;
         r_rdata <= '0;
         r_rbv   <= 1'b0;
         r_rlast <= 1'b0;
         r_bresp <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_rbv   <= 1'b0;
         r_rlast <= 1'b0;
         r_bresp <= 1'b0;
         if (w_start) begin
            r_addr <= i_addr;
            r_cnt  <= '0;
            r_err  <= 1'b0;
         end
         if (r_state == S_R && i_rvalid) begin
            r_rdata <= i_rdata;
            r_rbv   <= 1'b1;
            r_ridx  <= r_cnt;
            r_rlast <= i_rlast;
            if (!w_last) r_cnt <= r_cnt + 1'b1;
            if (i_rresp != RESP_OKAY || i_rlast != w_last) r_err <= 1'b1;
         end
         if (r_state == S_W && i_wready && !w_last) r_cnt <= r_cnt + 1'b1;
         if (r_state == S_B && i_bvalid) begin
            r_bresp <= 1'b1;
            if (i_bresp != RESP_OKAY) r_err <= 1'b1;
         end
      end
   assign o_busy            = r_state != S_IDLE;
   assign o_error           = r_err;
   assign o_read_data       = r_rdata;
   assign o_read_beat_valid = r_rbv;
   assign o_read_beat_idx   = r_ridx;
   assign o_read_last       = r_rlast;
   assign o_b_resp          = r_bresp;
   assign o_write_beat_idx  = r_cnt;
   assign o_araddr          = r_addr;
   assign o_arlen           = 8'(BLOCK_WORDS - 1);
   assign o_arsize          = 3'($clog2(DATA_WIDTH / 8));
   assign o_arburst         = BURST_INCR;
   assign o_arvalid         = r_state == S_AR;
   assign o_rready          = r_state == S_R;
   assign o_awaddr          = r_addr;
   assign o_awlen           = 8'(BLOCK_WORDS - 1);
   assign o_awsize          = 3'($clog2(DATA_WIDTH / 8));
   assign o_awburst         = BURST_INCR;
   assign o_awvalid         = r_state == S_AW;
   assign o_wvalid          = r_state == S_W;
   assign o_wdata           = i_write_data;
   assign o_wstrb           = '1;
   assign o_wlast           = (r_state == S_W) && w_last;
   assign o_bready          = r_state == S_B;
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: scoreboard bench for refill, writeback, error and reset-abort cases.
module tb_axi_burst_master;
   logic        clk = 0, arst = 0;
   logic        i_start_read = 0, i_start_write = 0;
   logic [31:0] i_addr = 0, i_write_data;
   logic [3:0]  o_write_beat_idx, o_read_beat_idx;
   logic [31:0] o_read_data;
   logic        o_read_beat_valid, o_read_last, o_b_resp, o_busy, o_error;
   logic [31:0] o_araddr, o_awaddr, o_wdata;
   logic [7:0]  o_arlen, o_awlen;
   logic [2:0]  o_arsize, o_awsize;
   logic [1:0]  o_arburst, o_awburst;
   logic        o_arvalid, i_arready = 0;
   logic [31:0] i_rdata = 0;
   logic [1:0]  i_rresp = 0;
   logic        i_rlast = 0, i_rvalid = 0, o_rready;
   logic        o_awvalid, i_awready = 0;
   logic [3:0]  o_wstrb;
   logic        o_wlast, o_wvalid, i_wready = 0;
   logic [1:0]  i_bresp = 0;
   logic        i_bvalid = 0, o_bready;
   typedef struct {int idx; logic [31:0] data; logic last;} beat_t;
   beat_t       rq[$], wq[$], e;
   logic [31:0] wmem[16];
   int          n_chk = 0, n_err = 0, n_b = 0, n_ar = 0;
   always #5 clk = ~clk;
   assign i_write_data = wmem[o_write_beat_idx];
   axi_burst_master dut (
      .clk(clk), .arst(arst), .i_start_read(i_start_read), .i_start_write(i_start_write),
      .i_addr(i_addr), .i_write_data(i_write_data), .o_write_beat_idx(o_write_beat_idx),
      .o_read_beat_idx(o_read_beat_idx), .o_read_data(o_read_data),
      .o_read_beat_valid(o_read_beat_valid), .o_read_last(o_read_last), .o_b_resp(o_b_resp),
      .o_busy(o_busy), .o_error(o_error), .o_araddr(o_araddr), .o_arlen(o_arlen),
      .o_arsize(o_arsize), .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
      .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
      .o_rready(o_rready), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
      .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready), .o_wdata(o_wdata),
      .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid), .i_wready(i_wready),
      .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      if (o_read_beat_valid) begin
         if (rq.size() == 0) check("rd_extra_beat", 1, 0);
         else begin
            e = rq.pop_front();
            check("rd_idx", 64'(o_read_beat_idx), 64'(e.idx));
            check("rd_data", 64'(o_read_data), 64'(e.data));
            check("rd_last", 64'(o_read_last), 64'(e.last));
         end
      end else if (o_read_last) check("rd_last_stray", 1, 0);
      if (o_wvalid && i_wready) begin
         if (wq.size() == 0) check("wr_extra_beat", 1, 0);
         else begin
            e = wq.pop_front();
            check("wr_idx", 64'(o_write_beat_idx), 64'(e.idx));
            check("wr_data", 64'(o_wdata), 64'(e.data));
            check("wr_last", 64'(o_wlast), 64'(e.last));
         end
      end else if (o_wlast && !o_wvalid) check("wlast_stray", 1, 0);
      if (o_b_resp) n_b++;
      if (o_arvalid) n_ar++;
   end
   task automatic check_idle_outputs(input string tag);
      check({tag, "_valids"}, 64'({o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready}), 0);
      check({tag, "_busy"}, 64'(o_busy), 0);
      check({tag, "_pulses"}, 64'({o_read_beat_valid, o_read_last, o_b_resp}), 0);
   endtask
   task automatic do_read(input logic [31:0] addr, input int ar_delay, input bit gap, input int rlast_at);
      i_start_read = 1;
      i_addr = addr;
      step();
      i_start_read = 0;
      check("ar_valid", 64'(o_arvalid), 1);
      check("ar_addr", 64'(o_araddr), 64'(addr));
      check("ar_len_size_burst", 64'({o_arlen, o_arsize, o_arburst}), 64'({8'd15, 3'd2, 2'b01}));
      check("rd_err_cleared", 64'(o_error), 0);
      for (int i = 0; i < ar_delay; i++) begin
         step();
         check("ar_hold", 64'({o_arvalid, o_araddr}), 64'({1'b1, addr}));
      end
      i_arready = 1;
      step();
      i_arready = 0;
      check("ar_drop", 64'({o_arvalid, o_rready}), 64'({1'b0, 1'b1}));
      for (int k = 0; k <= rlast_at;) begin
         if (gap && k[0] && i_rvalid) i_rvalid = 0;
         else begin
            i_rvalid = 1;
            i_rdata = $urandom;
            i_rlast = k == rlast_at;
            rq.push_back('{k, i_rdata, i_rlast});
            k++;
         end
         step();
      end
      i_rvalid = 0;
      i_rlast = 0;
      step();
      check("rd_done_busy", 64'(o_busy), 0);
      check("rd_error", 64'(o_error), 64'(rlast_at != 15));
      check("rd_queue_empty", 64'(rq.size()), 0);
   endtask
   task automatic do_write(input logic [31:0] addr, input logic [1:0] bresp, input bit also_read, input int abort_at);
      int b0, a0, s5, s11;
      b0 = n_b;
      a0 = n_ar;
      s5 = 0;
      s11 = 0;
      for (int k = 0; k < 16; k++) wmem[k] = $urandom;
      i_start_write = 1;
      i_start_read = also_read;
      i_addr = addr;
      step();
      i_start_write = 0;
      i_start_read = 0;
      check("aw_valid", 64'({o_awvalid, o_arvalid}), 64'({1'b1, 1'b0}));
      check("aw_addr", 64'(o_awaddr), 64'(addr));
      check("aw_len_size_burst", 64'({o_awlen, o_awsize, o_awburst}), 64'({8'd15, 3'd2, 2'b01}));
      step();
      i_awready = 1;
      step();
      i_awready = 0;
      check("aw_drop", 64'({o_awvalid, o_wvalid, o_wstrb}), 64'({1'b0, 1'b1, 4'hf}));
      for (int k = 0; k < 16;) begin
         if (k == abort_at) begin
            i_wready = 0;
            arst = 0;
            #1;
            check_idle_outputs("abort");
            check("abort_err_idx", 64'({o_error, o_write_beat_idx}), 0);
            step();
            step();
            arst = 1;
            step();
            check_idle_outputs("abort_release");
            check("abort_no_bresp", 64'(n_b - b0), 0);
            return;
         end
         if ((k == 5 && s5 == 0) || (k == 11 && s11 == 0)) begin
            i_wready = 0;
            if (k == 5) s5 = 1; else s11 = 1;
         end else begin
            i_wready = 1;
            wq.push_back('{k, wmem[k], k == 15});
            k++;
         end
         step();
      end
      i_wready = 0;
      check("w_to_b", 64'({o_wvalid, o_bready}), 64'({1'b0, 1'b1}));
      i_bvalid = 1;
      i_bresp = bresp;
      step();
      i_bvalid = 0;
      i_bresp = 0;
      check("b_pulse", 64'({o_b_resp, o_busy}), 64'({1'b1, 1'b0}));
      check("wr_error", 64'(o_error), 64'(bresp != 2'b00));
      step();
      check("b_pulse_single", 64'({o_b_resp, n_b - b0}), 64'({1'b0, 32'd1}));
      check("wr_queue_empty", 64'(wq.size()), 0);
      check("no_ar_during_write", 64'(n_ar - a0), 0);
   endtask
   initial begin
      step();
      check_idle_outputs("reset");
      check("reset_data_err", 64'({o_read_data, o_error, o_read_beat_idx, o_write_beat_idx}), 0);
      arst = 1;
      step();
      check_idle_outputs("post_reset");
      do_read(32'h0000_2000, 3, 1, 15);
      do_write(32'h0000_1040, 2'b00, 0, -1);
      do_write(32'h0000_3000, 2'b00, 1, -1);
      do_read(32'h0000_3000, 0, 0, 15);
      do_write(32'h0000_4000, 2'b10, 0, -1);
      do_read(32'h0000_5000, 1, 0, 9);
      do_read(32'h0000_6000, 2, 1, 15);
      do_write(32'h0000_7000, 2'b00, 0, 7);
      do_read(32'h0000_8000, 1, 1, 15);
      step();
      check("final_queues", 64'(rq.size() + wq.size()), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end
endmodule
